// File: rtl/io_request_queue_pkg.sv
// Shared types for the per-core IO request queue: thread/core indices and
// the request/response packets exchanged with the IO interconnect.
package io_request_queue_pkg;

    localparam int TOTAL_THREADS_PER_CORE = 4;
    localparam int THREAD_IDX_WIDTH = (TOTAL_THREADS_PER_CORE > 1) ? $clog2(TOTAL_THREADS_PER_CORE) : 1;
    localparam int NUM_CORES = 4;
    localparam int CORE_ID_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef logic [31:0] scalar_t;
    typedef logic [THREAD_IDX_WIDTH-1:0] local_thread_idx_t;
    typedef logic [CORE_ID_WIDTH-1:0] core_id_t;

    typedef struct packed {
        logic              store;
        scalar_t           address;
        scalar_t           value;
        local_thread_idx_t thread_idx;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t          core;
        local_thread_idx_t thread_idx;
        scalar_t           read_value;
    } iorsp_packet_t;

endpackage

// File: rtl/io_request_queue_if.sv
// Core-slot connection to the IO interconnect: one request channel out,
// grant and the broadcast response back in.
interface io_request_queue_if;
    import io_request_queue_pkg::*;

    logic          ior_request_valid;
    ioreq_packet_t ior_request;
    logic          ii_ready;
    logic          ii_response_valid;
    iorsp_packet_t ii_response;

    modport master (
        output ior_request_valid,
        output ior_request,
        input  ii_ready,
        input  ii_response_valid,
        input  ii_response
    );

    modport slave (
        input  ior_request_valid,
        input  ior_request,
        output ii_ready,
        output ii_response_valid,
        output ii_response
    );

endinterface

// File: rtl/oh_to_idx.sv
// One-hot to binary index encoder; an all-zero input yields index 0.
module oh_to_idx #(
    parameter int NUM_SIGNALS = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index
);

    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i])
                index = index | INDEX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last one granted has the
// highest priority; priority only advances when update_lru is asserted.
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    logic [NUM_REQUESTERS-1:0]   priority_oh_q;
    logic [NUM_REQUESTERS-1:0]   priority_oh_d;
    logic [NUM_REQUESTERS-1:0]   rotated_grant;
    logic [2*NUM_REQUESTERS-1:0] double_request;
    logic [2*NUM_REQUESTERS-1:0] double_grant;

    // Doubling the request vector lets one subtraction find the first
    // requester at or after the priority position, wrapping around.
    assign double_request = {request, request};
    assign double_grant = double_request
        & ~(double_request - {{NUM_REQUESTERS{1'b0}}, priority_oh_q});
    assign grant_oh = double_grant[NUM_REQUESTERS-1:0]
        | double_grant[2*NUM_REQUESTERS-1:NUM_REQUESTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_rotate
            assign rotated_grant[gi] = grant_oh[(gi + NUM_REQUESTERS - 1) % NUM_REQUESTERS];
        end
    endgenerate

    always_comb begin
        priority_oh_d = priority_oh_q;
        if (update_lru && |request)
            priority_oh_d = rotated_grant;
    end

    always_ff @(posedge clk) begin
        if (reset)
            priority_oh_q <= NUM_REQUESTERS'(1);
        else
            priority_oh_q <= priority_oh_d;
    end

endmodule

// File: rtl/io_request_queue.sv
// Per-core IO request queue: parks threads on uncached IO accesses, issues one
// request at a time round-robin, and completes the replayed access on response.
// Optional IO_QUEUE_PERF_EN adds the ior_perf_io_wait performance output.
module io_request_queue
    import io_request_queue_pkg::*;
#(
    parameter int THREADS_PER_CORE = 4,
    parameter int CORE_ID = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dd_io_write_en,
    input  logic                        dd_io_read_en,
    input  local_thread_idx_t           dd_io_thread_idx,
    input  scalar_t                     dd_io_addr,
    input  scalar_t                     dd_io_write_value,
    output logic                        ior_rollback_en,
    output logic                        ior_access_complete,
    output scalar_t                     ior_read_value,
    output logic [THREADS_PER_CORE-1:0] ior_pending,
    output logic [THREADS_PER_CORE-1:0] ior_wake_bitmap,
`ifdef IO_QUEUE_PERF_EN
    output logic                        ior_perf_io_wait,
`endif
    io_request_queue_if.master          io_bus
);

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_QUEUED,
        IO_ISSUED,
        IO_DONE
    } io_entry_state_t;

    io_entry_state_t state_q [THREADS_PER_CORE];
    io_entry_state_t state_d [THREADS_PER_CORE];
    logic            store_q [THREADS_PER_CORE];
    logic            store_d [THREADS_PER_CORE];
    scalar_t         address_q [THREADS_PER_CORE];
    scalar_t         address_d [THREADS_PER_CORE];
    scalar_t         value_q [THREADS_PER_CORE];
    scalar_t         value_d [THREADS_PER_CORE];
    scalar_t         read_value_q [THREADS_PER_CORE];
    scalar_t         read_value_d [THREADS_PER_CORE];

    logic [THREADS_PER_CORE-1:0] wake_q;
    logic [THREADS_PER_CORE-1:0] wake_d;
    logic [THREADS_PER_CORE-1:0] held_oh_q;
    logic [THREADS_PER_CORE-1:0] held_oh_d;
    logic                        held_valid_q;
    logic                        held_valid_d;

    logic [THREADS_PER_CORE-1:0] access_sel;
    logic [THREADS_PER_CORE-1:0] response_sel;
    logic [THREADS_PER_CORE-1:0] queued;
    logic [THREADS_PER_CORE-1:0] arb_request;
    logic [THREADS_PER_CORE-1:0] grant_oh;
    local_thread_idx_t           grant_idx;
    logic                        access_en;
    logic                        response_for_core;
    logic                        issue_en;
    io_entry_state_t             dd_state;
    logic                        dd_known;
    scalar_t                     dd_read_value;

    assign access_en = dd_io_write_en | dd_io_read_en;
    assign response_for_core = io_bus.ii_response_valid
        && (io_bus.ii_response.core == core_id_t'(CORE_ID));

    genvar gi;
    generate
        for (gi = 0; gi < THREADS_PER_CORE; gi++) begin : g_entry_decode
            assign access_sel[gi] = access_en && (dd_io_thread_idx == local_thread_idx_t'(gi));
            assign response_sel[gi] = response_for_core
                && (io_bus.ii_response.thread_idx == local_thread_idx_t'(gi));
            assign queued[gi] = (state_q[gi] == IO_QUEUED);
            assign ior_pending[gi] = (state_q[gi] != IO_IDLE);
        end
    endgenerate

    assign io_bus.ior_request_valid = !reset && |queued;
    assign issue_en = io_bus.ior_request_valid && io_bus.ii_ready;

    // While a presented request waits for the grant, the arbiter only sees
    // that entry, so newly queued threads cannot displace it.
    assign arb_request = held_valid_q ? held_oh_q : queued;
    assign held_valid_d = io_bus.ior_request_valid && !io_bus.ii_ready;
    assign held_oh_d = grant_oh;

    rr_arbiter #(
        .NUM_REQUESTERS(THREADS_PER_CORE)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .request   (arb_request),
        .update_lru(io_bus.ii_ready),
        .grant_oh  (grant_oh)
    );

    oh_to_idx #(
        .NUM_SIGNALS(THREADS_PER_CORE),
        .INDEX_WIDTH(THREAD_IDX_WIDTH)
    ) u_grant_idx (
        .one_hot(grant_oh),
        .index  (grant_idx)
    );

    always_comb begin
        io_bus.ior_request = '0;
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            if (grant_oh[i]) begin
                io_bus.ior_request.store   = store_q[i];
                io_bus.ior_request.address = address_q[i];
                io_bus.ior_request.value   = value_q[i];
            end
        end
        io_bus.ior_request.thread_idx = grant_idx;
    end

    always_comb begin
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            state_d[i]      = state_q[i];
            store_d[i]      = store_q[i];
            address_d[i]    = address_q[i];
            value_d[i]      = value_q[i];
            read_value_d[i] = read_value_q[i];
            wake_d[i]       = 1'b0;
            case (state_q[i])
                IO_IDLE: begin
                    if (access_sel[i]) begin
                        state_d[i]   = IO_QUEUED;
                        store_d[i]   = dd_io_write_en;
                        address_d[i] = dd_io_addr;
                        value_d[i]   = dd_io_write_value;
                    end
                end
                IO_QUEUED: begin
                    if (issue_en && grant_oh[i])
                        state_d[i] = IO_ISSUED;
                end
                IO_ISSUED: begin
                    if (response_sel[i]) begin
                        state_d[i]      = IO_DONE;
                        read_value_d[i] = io_bus.ii_response.read_value;
                        wake_d[i]       = 1'b1;
                    end
                end
                IO_DONE: begin
                    if (access_sel[i])
                        state_d[i] = IO_IDLE;
                end
                default: state_d[i] = IO_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < THREADS_PER_CORE; i++)
                state_q[i] <= IO_IDLE;
            wake_q       <= '0;
            held_oh_q    <= '0;
            held_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < THREADS_PER_CORE; i++)
                state_q[i] <= state_d[i];
            wake_q       <= wake_d;
            held_oh_q    <= held_oh_d;
            held_valid_q <= held_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            store_q[i]      <= store_d[i];
            address_q[i]    <= address_d[i];
            value_q[i]      <= value_d[i];
            read_value_q[i] <= read_value_d[i];
        end
    end

    always_comb begin
        dd_state      = IO_IDLE;
        dd_known      = 1'b0;
        dd_read_value = '0;
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            if (dd_io_thread_idx == local_thread_idx_t'(i)) begin
                dd_known      = 1'b1;
                dd_state      = state_q[i];
                dd_read_value = read_value_q[i];
            end
        end
        ior_access_complete = !reset && access_en && (dd_state == IO_DONE);
        ior_rollback_en     = !reset && access_en && dd_known && (dd_state != IO_DONE);
        ior_read_value      = ior_access_complete ? dd_read_value : '0;
    end

    assign ior_wake_bitmap = wake_q;

`ifdef IO_QUEUE_PERF_EN
    always_comb begin
        ior_perf_io_wait = 1'b0;
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            if (state_q[i] == IO_QUEUED || state_q[i] == IO_ISSUED)
                ior_perf_io_wait = 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Responses for entries discarded by a reset are expected stragglers.
    logic [THREADS_PER_CORE-1:0] stale_ok_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < THREADS_PER_CORE; i++) begin
                if (state_q[i] == IO_ISSUED)
                    stale_ok_q[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < THREADS_PER_CORE; i++) begin
                assert (!(access_sel[i] && (state_q[i] == IO_QUEUED || state_q[i] == IO_ISSUED)))
                    else $error("io_request_queue: access from suspended thread %0d", i);
                if (response_sel[i]) begin
                    assert (state_q[i] == IO_ISSUED || stale_ok_q[i])
                        else $error("io_request_queue: response for thread %0d not issued", i);
                    stale_ok_q[i] <= 1'b0;
                end else if (access_sel[i]) begin
                    stale_ok_q[i] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_request_queue.sv
// Randomized bench for io_request_queue with a set-based reference model of
// thread states, a round-robin grant model and a behavioural interconnect.
module tb_io_request_queue;
    import io_request_queue_pkg::*;

    localparam int T = 4;
    localparam int CORE = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              dd_io_write_en;
    logic              dd_io_read_en;
    local_thread_idx_t dd_io_thread_idx;
    scalar_t           dd_io_addr;
    scalar_t           dd_io_write_value;
    logic              ior_rollback_en;
    logic              ior_access_complete;
    scalar_t           ior_read_value;
    logic [T-1:0]      ior_pending;
    logic [T-1:0]      ior_wake_bitmap;
`ifdef IO_QUEUE_PERF_EN
    logic              ior_perf_io_wait;
`endif

    io_request_queue_if bus ();

    io_request_queue #(
        .THREADS_PER_CORE(T),
        .CORE_ID(CORE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dd_io_write_en     (dd_io_write_en),
        .dd_io_read_en      (dd_io_read_en),
        .dd_io_thread_idx   (dd_io_thread_idx),
        .dd_io_addr         (dd_io_addr),
        .dd_io_write_value  (dd_io_write_value),
        .ior_rollback_en    (ior_rollback_en),
        .ior_access_complete(ior_access_complete),
        .ior_read_value     (ior_read_value),
        .ior_pending        (ior_pending),
        .ior_wake_bitmap    (ior_wake_bitmap),
`ifdef IO_QUEUE_PERF_EN
        .ior_perf_io_wait   (ior_perf_io_wait),
`endif
        .io_bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          thread;
        logic [31:0] value;
    } rsp_t;
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: which set each thread is in.
    logic [T-1:0] m_wait, m_flight, m_done, m_wake;
    logic         m_store [T];
    logic [31:0]  m_addr [T];
    logic [31:0]  m_val [T];
    logic [31:0]  m_rsp [T];
    int           m_last;
    bit           m_hold_valid;
    int           m_hold;
    int           grant_log[$];

    int          drv_acc;
    int          drv_thread;
    logic [31:0] drv_addr, drv_val;
    bit          drv_ready, drv_reset, force_foreign, foreign_en, rand_latency, fixed_rsp_en;
    logic [31:0] fixed_rsp_value;

    logic         obs_complete, obs_rollback, obs_req_valid, obs_req_store;
    logic [31:0]  obs_read_value, obs_req_addr, obs_req_value;
    logic [T-1:0] obs_pending, obs_wake;
    int           obs_req_thread;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= T; k++) begin
            int c;
            c = (m_last + k) % T;
            if (m_wait[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_wait = '0; m_flight = '0; m_done = '0; m_wake = '0;
        m_last = T - 1; m_hold_valid = 0; m_hold = 0;
    endtask

    // One clock cycle: drive, compare against the model, clock, update model.
    task automatic step();
        bit   rv;
        rsp_t r;
        int   g;
        int   t;
        bit   any_wait;
        logic [T-1:0] new_wake;
        rv = 0; g = -1; t = drv_thread;
        bus.ii_response_valid = 1'b0;
        bus.ii_response = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            rv = 1;
            r = rsp_q.pop_front();
            bus.ii_response_valid = 1'b1;
            bus.ii_response.core = core_id_t'(CORE);
            bus.ii_response.thread_idx = local_thread_idx_t'(r.thread);
            bus.ii_response.read_value = r.value;
        end else if (force_foreign || (foreign_en && $urandom_range(0, 9) == 0)) begin
            bus.ii_response_valid = 1'b1;
            bus.ii_response.core = core_id_t'(CORE + 1 + $urandom_range(0, 2));
            bus.ii_response.thread_idx = local_thread_idx_t'(force_foreign ? drv_thread : $urandom_range(0, T - 1));
            bus.ii_response.read_value = $urandom;
        end
        dd_io_read_en = (drv_acc == 1);
        dd_io_write_en = (drv_acc == 2);
        dd_io_thread_idx = local_thread_idx_t'(drv_thread);
        dd_io_addr = drv_addr;
        dd_io_write_value = drv_val;
        bus.ii_ready = drv_ready;
        reset = drv_reset;
        #1;
        obs_complete = ior_access_complete; obs_rollback = ior_rollback_en;
        obs_read_value = ior_read_value; obs_req_valid = bus.ior_request_valid;
        obs_req_store = bus.ior_request.store; obs_req_addr = bus.ior_request.address;
        obs_req_value = bus.ior_request.value; obs_req_thread = int'(bus.ior_request.thread_idx);
        obs_pending = ior_pending; obs_wake = ior_wake_bitmap;
        any_wait = (m_wait != '0);
        if (drv_reset) begin
            check_eq("rst_req_valid", 64'(obs_req_valid), 64'(0));
            check_eq("rst_rollback", 64'(obs_rollback), 64'(0));
            check_eq("rst_complete", 64'(obs_complete), 64'(0));
            check_eq("rst_read_value", 64'(obs_read_value), 64'(0));
        end else begin
            check_eq("req_valid", 64'(obs_req_valid), 64'(any_wait));
            if (any_wait) begin
                g = m_hold_valid ? m_hold : rr_pick();
                check_eq("req_thread", 64'(obs_req_thread), 64'(g));
                check_eq("req_store", 64'(obs_req_store), 64'(m_store[g]));
                check_eq("req_addr", 64'(obs_req_addr), 64'(m_addr[g]));
                check_eq("req_value", 64'(obs_req_value), 64'(m_val[g]));
            end
            check_eq("pending", 64'(obs_pending), 64'(m_wait | m_flight | m_done));
            check_eq("wake", 64'(obs_wake), 64'(m_wake));
            if (drv_acc != 0 && m_done[t]) begin
                check_eq("replay_complete", 64'(obs_complete), 64'(1));
                check_eq("replay_rollback", 64'(obs_rollback), 64'(0));
                check_eq("replay_value", 64'(obs_read_value), 64'(m_rsp[t]));
            end else begin
                check_eq("accept_rollback", 64'(obs_rollback), 64'(drv_acc != 0));
                check_eq("no_complete", 64'(obs_complete), 64'(0));
                check_eq("idle_read_value", 64'(obs_read_value), 64'(0));
            end
`ifdef IO_QUEUE_PERF_EN
            check_eq("perf_io_wait", 64'(ior_perf_io_wait), 64'((m_wait | m_flight) != '0));
`endif
        end
        @(posedge clk);
        if (drv_reset) begin
            model_clear();
        end else begin
            new_wake = '0;
            if (any_wait) begin
                if (drv_ready) begin
                    m_wait[g] = 1'b0; m_flight[g] = 1'b1; m_last = g; m_hold_valid = 0;
                    grant_log.push_back(g);
                    rsp_q.push_back('{due: cyc + (rand_latency ? $urandom_range(1, 4) : 2),
                                      thread: g,
                                      value: fixed_rsp_en ? fixed_rsp_value : $urandom});
                end else begin
                    m_hold_valid = 1; m_hold = g;
                end
            end
            if (rv && m_flight[r.thread]) begin
                m_flight[r.thread] = 1'b0; m_done[r.thread] = 1'b1;
                m_rsp[r.thread] = r.value; new_wake[r.thread] = 1'b1;
            end
            if (drv_acc != 0) begin
                if (m_done[t]) begin
                    m_done[t] = 1'b0;
                end else begin
                    m_wait[t] = 1'b1; m_store[t] = (drv_acc == 2);
                    m_addr[t] = drv_addr; m_val[t] = drv_val;
                end
            end
            m_wake = new_wake;
        end
        cyc++;
        drv_acc = 0;
        force_foreign = 0;
        @(negedge clk);
    endtask

    task automatic access(int t, int kind, logic [31:0] addr, logic [31:0] val);
        drv_thread = t; drv_acc = kind; drv_addr = addr; drv_val = val;
        step();
    endtask

    // Grant everything and replay finished threads until the queue empties.
    task automatic drain();
        bit busy;
        busy = 1;
        drv_ready = 1;
        for (int n = 0; n < 80 && busy; n++) begin
            busy = ((m_wait | m_flight | m_done) != '0) || (rsp_q.size() != 0);
            if (busy) begin
                for (int k = 0; k < T; k++) begin
                    if (drv_acc == 0 && m_done[k] && !m_wake[k]) begin
                        drv_thread = k; drv_acc = m_store[k] ? 2 : 1;
                        drv_addr = m_addr[k]; drv_val = m_val[k];
                    end
                end
                step();
            end
        end
        busy = ((m_wait | m_flight | m_done) != '0) || (rsp_q.size() != 0);
        check_eq("drain_done", 64'(busy), 64'(0));
        drv_ready = 0;
    endtask

    initial begin
        model_clear();
        drv_acc = 0; drv_thread = 0; drv_addr = '0; drv_val = '0;
        drv_ready = 0; force_foreign = 0; foreign_en = 0; rand_latency = 0;
        fixed_rsp_en = 1; fixed_rsp_value = 32'hDEADBEEF;
        for (int k = 0; k < T; k++) begin
            m_store[k] = 0; m_addr[k] = '0; m_val[k] = '0; m_rsp[k] = '0;
        end
        @(negedge clk);
        drv_reset = 1;
        step();
        step();
        drv_reset = 0;
        step();
        check_eq("reset_pending", 64'(obs_pending), 64'(0));
        check_eq("reset_wake", 64'(obs_wake), 64'(0));

        // Single load from thread 1.
        access(1, 1, 32'h100, 32'h0);
        check_eq("load_rollback", 64'(obs_rollback), 64'(1));
        drv_ready = 1;
        step();
        check_eq("load_req_valid", 64'(obs_req_valid), 64'(1));
        check_eq("load_req_thread", 64'(obs_req_thread), 64'(1));
        check_eq("load_req_addr", 64'(obs_req_addr), 64'(32'h100));
        drv_ready = 0;
        step();
        step();
        step();
        check_eq("load_wake", 64'(obs_wake), 64'(4'b0010));
        access(1, 1, 32'h100, 32'h0);
        check_eq("load_complete", 64'(obs_complete), 64'(1));
        check_eq("load_value", 64'(obs_read_value), 64'(32'hDEADBEEF));
        step();
        check_eq("load_pending_clear", 64'(obs_pending), 64'(0));

        // Store from thread 0.
        fixed_rsp_value = 32'hCAFEF00D;
        access(0, 2, 32'h4, 32'h12345678);
        step();
        check_eq("store_flag", 64'(obs_req_store), 64'(1));
        check_eq("store_addr", 64'(obs_req_addr), 64'(32'h4));
        check_eq("store_value", 64'(obs_req_value), 64'(32'h12345678));
        drain();

        // Four threads back to back with ii_ready every cycle.
        grant_log.delete();
        drv_ready = 1;
        for (int k = 0; k < T; k++) access(k, 1, 32'h200 + 32'(k * 4), 32'h0);
        drain();
        check_eq("order_count", 64'(grant_log.size()), 64'(4));
        for (int k = 0; k < T && k < grant_log.size(); k++)
            check_eq("order_grant", 64'(grant_log[k]), 64'(k));

        // ii_ready withheld: presented request must stay put.
        access(2, 2, 32'h300, 32'hA5A5A5A5);
        access(3, 1, 32'h304, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("hold_thread", 64'(obs_req_thread), 64'(2));
            check_eq("hold_addr", 64'(obs_req_addr), 64'(32'h300));
        end
        drain();

        // Response tagged with another core is ignored.
        access(1, 1, 32'h400, 32'h0);
        drv_ready = 1;
        step();
        drv_ready = 0;
        drv_thread = 1; force_foreign = 1;
        step();
        step();
        check_eq("foreign_no_wake", 64'(obs_wake), 64'(0));
        check_eq("foreign_pending", 64'(obs_pending), 64'(4'b0010));
        drain();

        // Reset while thread 2 is issued; the late response must be dropped.
        access(2, 1, 32'h500, 32'h0);
        drv_ready = 1;
        step();
        drv_ready = 0;
        drv_reset = 1;
        step();
        drv_reset = 0;
        step();
        check_eq("stale_pending", 64'(obs_pending), 64'(0));
        step();
        check_eq("stale_no_wake", 64'(obs_wake), 64'(0));
        check_eq("stale_pending_after", 64'(obs_pending), 64'(0));

        // Randomized traffic.
        fixed_rsp_en = 0; foreign_en = 1; rand_latency = 1;
        repeat (1500) begin
            int t;
            drv_ready = ($urandom_range(0, 9) < 7);
            t = $urandom_range(0, T - 1);
            if ($urandom_range(0, 2) != 0 && !m_wait[t] && !m_flight[t] && !(m_done[t] && m_wake[t])) begin
                drv_thread = t;
                drv_acc = m_done[t] ? (m_store[t] ? 2 : 1) : $urandom_range(1, 2);
                drv_addr = m_done[t] ? m_addr[t] : $urandom;
                drv_val = m_done[t] ? m_val[t] : $urandom;
            end
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
